// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and depth helper for the synchronous FIFO
package fifo_pkg;

  localparam int FIFO_DATA_W_DEF    = 9;
  localparam int FIFO_ADDR_W_DEF    = 4;
  localparam int FIFO_AF_THRESH_DEF = 12;
  localparam int FIFO_AE_THRESH_DEF = 2;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// rtl/fifo_ram_dp.sv - simple dual-port RAM, synchronous write, registered read
module fifo_ram_dp
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Array itself is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised synchronous FIFO: pointers, occupancy and flags
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W_DEF,
  parameter int ADDR_W    = FIFO_ADDR_W_DEF,
  parameter int AF_THRESH = FIFO_AF_THRESH_DEF,
  parameter int AE_THRESH = FIFO_AE_THRESH_DEF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_LVL = CNT_W'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL = CNT_W'(AE_THRESH);

  logic [ADDR_W:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_W:0] rd_ptr_d, rd_ptr_q;
  logic [ADDR_W:0] count_d, count_q;
  logic            full_d, full_q;
  logic            empty_d, empty_q;
  logic            af_d, af_q;
  logic            ae_d, ae_q;
  logic            ovf_d, ovf_q;
  logic            udf_d, udf_q;
  logic            rd_valid_d, rd_valid_q;
  logic            wr_accept;
  logic            rd_accept;

  // Acceptance looks only at registered flags, so a full FIFO never takes a
  // write on the strength of a same-cycle read, and an empty one never falls through.
  assign wr_accept = wr_en && !full_q && !flush;
  assign rd_accept = rd_en && !empty_q && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    rd_valid_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      wr_ptr_d   = wr_ptr_q + {{ADDR_W{1'b0}}, wr_accept};
      rd_ptr_d   = rd_ptr_q + {{ADDR_W{1'b0}}, rd_accept};
      ovf_d      = ovf_q || (wr_en && full_q);
      udf_d      = udf_q || (rd_en && empty_q);
      rd_valid_d = rd_accept;
    end
  end

  // Status is derived from the next pointers so every flag comes straight off a flop.
  always_comb begin
    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
              (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    af_d    = (count_d >= AF_LVL);
    ae_d    = (count_d <= AE_LVL);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_ram_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset_b (reset_b),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

  logic       clk;
  logic       reset_b;
  logic       flush;
  logic       wr_en;
  logic [8:0] wr_data;
  logic       rd_en;
  logic [8:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int n_cmp;
  int n_bad;

  sync_fifo_param dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic w, input logic [8:0] d, input logic r);
    flush   = f;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'h0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_full"}, 32'(full), 32'h0);
    chk({tag, "_empty"}, 32'(empty), 32'h1);
    chk({tag, "_aempty"}, 32'(almost_empty), 32'h1);
    chk({tag, "_afull"}, 32'(almost_full), 32'h0);
    chk({tag, "_ovf"}, 32'(overflow), 32'h0);
    chk({tag, "_udf"}, 32'(underflow), 32'h0);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_b = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    repeat (3) tick();
    chk_reset_state("por");
    reset_b = 1'b1;
    tick();

    // fill 0x001..0x010, then one write too many
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, 9'(i), 1'b0);
      chk($sformatf("fill%0d_count", i), 32'(count), 32'(i));
      chk($sformatf("fill%0d_afull", i), 32'(almost_full), (i >= 12) ? 32'h1 : 32'h0);
      chk($sformatf("fill%0d_full", i), 32'(full), (i == 16) ? 32'h1 : 32'h0);
    end
    drive(1'b0, 1'b1, 9'h1FF, 1'b0);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_count", 32'(count), 32'd16);

    // drain in order
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b0, 9'h0, 1'b1);
      chk($sformatf("drain%0d_data", i), 32'(rd_data), 32'(i));
      chk($sformatf("drain%0d_valid", i), 32'(rd_valid), 32'h1);
      chk($sformatf("drain%0d_count", i), 32'(count), 32'(16 - i));
    end
    chk("drain_empty", 32'(empty), 32'h1);
    chk("drain_aempty", 32'(almost_empty), 32'h1);
    drive(1'b0, 1'b0, 9'h0, 1'b1);
    chk("udf_set", 32'(underflow), 32'h1);
    chk("udf_valid", 32'(rd_valid), 32'h0);
    chk("udf_hold_data", 32'(rd_data), 32'h010);

    drive(1'b1, 1'b0, 9'h0, 1'b0);
    chk("flush1_ovf", 32'(overflow), 32'h0);
    chk("flush1_udf", 32'(underflow), 32'h0);

    // steady occupancy 8 with simultaneous write and read
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 9'(32'h100 + i), 1'b0);
    chk("steady_pre_count", 32'(count), 32'd8);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 9'(32'h108 + i), 1'b1);
      chk($sformatf("steady%0d_data", i), 32'(rd_data), 32'h100 + 32'(i));
      chk($sformatf("steady%0d_count", i), 32'(count), 32'd8);
    end

    // empty with simultaneous write and read
    drive(1'b1, 1'b0, 9'h0, 1'b0);
    drive(1'b0, 1'b1, 9'h055, 1'b1);
    chk("wr_rd_empty_count", 32'(count), 32'd1);
    chk("wr_rd_empty_valid", 32'(rd_valid), 32'h0);
    chk("wr_rd_empty_udf", 32'(underflow), 32'h1);
    drive(1'b0, 1'b0, 9'h0, 1'b1);
    chk("wr_rd_empty_data", 32'(rd_data), 32'h055);
    chk("wr_rd_empty_valid2", 32'(rd_valid), 32'h1);

    // flush at count 10 with overflow set, write requested during flush
    drive(1'b1, 1'b0, 9'h0, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 9'(32'h0A0 + i), 1'b0);
    drive(1'b0, 1'b1, 9'h1FF, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 9'h0, 1'b1);
    chk("pre_flush_count", 32'(count), 32'd10);
    chk("pre_flush_ovf", 32'(overflow), 32'h1);
    chk("pre_flush_data", 32'(rd_data), 32'h0A5);
    drive(1'b1, 1'b1, 9'h1EE, 1'b0);
    chk("flush2_count", 32'(count), 32'd0);
    chk("flush2_empty", 32'(empty), 32'h1);
    chk("flush2_ovf", 32'(overflow), 32'h0);
    chk("flush2_valid", 32'(rd_valid), 32'h0);
    tick();
    chk("flush2_nowrite", 32'(count), 32'd0);
    drive(1'b0, 1'b1, 9'h033, 1'b0);
    drive(1'b0, 1'b0, 9'h0, 1'b1);
    chk("flush2_next_data", 32'(rd_data), 32'h033);

    // asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 9'(32'h0C0 + i), 1'b0);
    chk("mid_count", 32'(count), 32'd5);
    rd_en = 1'b1;
    tick();
    chk("mid_inflight_valid", 32'(rd_valid), 32'h1);
    #2;
    reset_b = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    rd_en = 1'b0;
    reset_b = 1'b1;
    drive(1'b0, 1'b1, 9'h1AA, 1'b0);
    chk("post_rst_count", 32'(count), 32'd1);
    drive(1'b0, 1'b0, 9'h0, 1'b1);
    chk("post_rst_data", 32'(rd_data), 32'h1AA);
    chk("post_rst_valid", 32'(rd_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
